// File: rtl/mem_dump_tx_pkg.sv
// Shared definitions for the UART memory readback path: FSM state encoding,
// terminator default and loader base address.
package mem_dump_tx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        RD_WAIT,
        HI,
        HI_GAP,
        LO,
        LO_GAP,
        NEXT,
        TERM_HI,
        TERM_GAP,
        TERM_LO,
        TERM_GAP2,
        FIN
    } dump_state_t;

    localparam logic [15:0] TERM_WORD_DEFAULT = 16'hFFFF;
    localparam logic [11:0] LOAD_BASE_ADDR    = 12'h300;

    function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi_sel);
        return hi_sel ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/mem_dump_tx_if.sv
// Memory read port and UART transmit handshake seen by the readback engine.
interface mem_dump_tx_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_rd_data;
    logic [7:0]            tx_data;
    logic                  tx_en;
    logic                  tx_busy;

    modport master (
        output mem_rd, mem_addr, tx_data, tx_en,
        input  mem_rd_data, tx_busy
    );

    modport slave (
        input  mem_rd, mem_addr, tx_data, tx_en,
        output mem_rd_data, tx_busy
    );
endinterface

// File: rtl/mem_dump_tx.sv
// Streams count 16-bit words from memory to the UART, high byte first,
// optionally followed by a terminator word.
//
// state     | meaning
// IDLE      | waiting for start
// RD        | mem_rd strobe at addr
// RD_WAIT   | read data returns, captured into word
// HI        | wait !tx_busy, send word[15:8]
// HI_GAP    | guard cycle for late tx_busy
// LO        | wait !tx_busy, send word[7:0]
// LO_GAP    | guard cycle
// NEXT      | advance addr, decrement remaining
// TERM_HI   | send terminator high byte
// TERM_GAP  | guard cycle
// TERM_LO   | send terminator low byte
// TERM_GAP2 | guard cycle
// FIN       | done pulse
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          CNT_WIDTH  = 11,
    parameter bit          SEND_TERM  = 1'b1,
    parameter logic [15:0] TERM_WORD  = TERM_WORD_DEFAULT
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    mem_dump_tx_if.master         bus
);

    dump_state_t           state, state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [15:0]           word;
    logic                  mem_rd;
    logic                  tx_en;
    logic [7:0]            tx_data;
    logic                  tx_ok;

    // No byte is launched in a cycle where abort is being taken.
    assign tx_ok = !bus.tx_busy && !abort;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start && !abort) begin
                addr      <= {start_addr[ADDR_WIDTH-1:1], 1'b0};
                remaining <= count;
            end
            if (state == RD_WAIT) begin
                word <= bus.mem_rd_data;
            end
            if (state == NEXT) begin
                remaining <= remaining - CNT_WIDTH'(1);
                addr      <= addr + ADDR_WIDTH'(2);
            end
        end
    end

    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        tx_en    = 1'b0;
        tx_data  = 8'h00;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_nx = SEND_TERM ? TERM_HI : FIN;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            RD: begin
                mem_rd   = 1'b1;
                state_nx = RD_WAIT;
            end
            RD_WAIT: state_nx = HI;
            HI: begin
                tx_data = word_byte(word, 1'b1);
                if (tx_ok) begin
                    tx_en    = 1'b1;
                    state_nx = HI_GAP;
                end
            end
            HI_GAP: state_nx = LO;
            LO: begin
                tx_data = word_byte(word, 1'b0);
                if (tx_ok) begin
                    tx_en    = 1'b1;
                    state_nx = LO_GAP;
                end
            end
            LO_GAP: state_nx = NEXT;
            NEXT: begin
                if (remaining == CNT_WIDTH'(1)) begin
                    state_nx = SEND_TERM ? TERM_HI : FIN;
                end else begin
                    state_nx = RD;
                end
            end
            TERM_HI: begin
                tx_data = word_byte(TERM_WORD, 1'b1);
                if (tx_ok) begin
                    tx_en    = 1'b1;
                    state_nx = TERM_GAP;
                end
            end
            TERM_GAP: state_nx = TERM_LO;
            TERM_LO: begin
                tx_data = word_byte(TERM_WORD, 1'b0);
                if (tx_ok) begin
                    tx_en    = 1'b1;
                    state_nx = TERM_GAP2;
                end
            end
            TERM_GAP2: state_nx = FIN;
            FIN:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
        end
    end

    assign bus.mem_rd   = mem_rd;
    assign bus.mem_addr = addr;
    assign bus.tx_en    = tx_en;
    assign bus.tx_data  = tx_data;
    assign busy         = (state != IDLE) && (state != FIN);
    assign done         = (state == FIN);

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: word memory with 1-cycle read latency and a UART
// model with configurable busy length and rise lag.
module tb_mem_dump_tx;
    import mem_dump_tx_pkg::*;

    localparam int AW = 12;
    localparam int CW = 11;

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start, abort, start0;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] count;
    logic          busy, done, busy0, done0;

    always #5 sys_clk = ~sys_clk;

    mem_dump_tx_if #(.ADDR_WIDTH(AW)) if1 ();
    mem_dump_tx_if #(.ADDR_WIDTH(AW)) if0 ();

    mem_dump_tx #(
        .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .SEND_TERM(1'b1), .TERM_WORD(TERM_WORD_DEFAULT)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .count(count), .abort(abort), .busy(busy), .done(done), .bus(if1)
    );

    mem_dump_tx #(
        .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .SEND_TERM(1'b0), .TERM_WORD(TERM_WORD_DEFAULT)
    ) dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start0), .start_addr(LOAD_BASE_ADDR),
        .count(11'd0), .abort(1'b0), .busy(busy0), .done(done0), .bus(if0)
    );

    assign if0.tx_busy     = 1'b0;
    assign if0.mem_rd_data = 16'h0000;

    // memory model
    logic [15:0]   mem [0:2047];
    logic [AW-1:0] rd_q [$];
    logic [7:0]    tx_q [$];

    always @(posedge sys_clk) begin
        if (if1.mem_rd) begin
            rd_q.push_back(if1.mem_addr);
            if1.mem_rd_data <= mem[if1.mem_addr[AW-1:1]];
        end
    end

    // UART model
    int     lag, hold;
    int     busy_left;
    logic   pend, have_last;
    int     viol = 0, gap_viol = 0;
    longint cyc = 0, last_en = 0;
    int     en0_cnt = 0, rd0_cnt = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left <= 0;
            pend      <= 1'b0;
            have_last <= 1'b0;
        end else begin
            if (if1.tx_en) begin
                tx_q.push_back(if1.tx_data);
                if (if1.tx_busy) viol <= viol + 1;
                if (have_last && (cyc - last_en < 2)) gap_viol <= gap_viol + 1;
                have_last <= 1'b1;
                last_en   <= cyc;
                if (lag != 0) begin
                    pend <= 1'b1;
                end else begin
                    pend      <= 1'b0;
                    busy_left <= hold;
                end
            end else if (pend) begin
                pend      <= 1'b0;
                busy_left <= hold;
            end else if (busy_left > 0) begin
                busy_left <= busy_left - 1;
            end
        end
    end

    assign if1.tx_busy = (busy_left != 0);

    always @(posedge sys_clk) begin
        if (if0.tx_en)  en0_cnt <= en0_cnt + 1;
        if (if0.mem_rd) rd0_cnt <= rd0_cnt + 1;
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] cnt;
        logic [AW-1:0] raddr0;
        logic [7:0]    lag;
        logic [7:0]    hold;
        logic          poke;
        logic [3:0]    nexp;
        logic [63:0]   exp;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v, input int idx);
        int            tb0, rb0, v0, g0, got;
        bit            seen;
        logic [AW-1:0] ea;
        tb0  = tx_q.size();
        rb0  = rd_q.size();
        v0   = viol;
        g0   = gap_viol;
        seen = 1'b0;
        lag  = int'(v.lag);
        hold = int'(v.hold);
        @(negedge sys_clk);
        start = 1'b1; start_addr = v.addr; count = v.cnt;
        @(negedge sys_clk);
        start = 1'b0; start_addr = 12'h400; count = 11'd5;
        chk($sformatf("v%0d_busy_after_start", idx), 32'(busy), 32'd1);
        for (int c = 0; c < 1500; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = v.poke && (c == 3);
            @(negedge sys_clk);
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), 32'(seen), 32'd1);
        @(negedge sys_clk);
        chk($sformatf("v%0d_done_pulse_end", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_nbytes", idx), tx_q.size() - tb0, 32'(v.nexp));
        for (int i = 0; i < int'(v.nexp); i++) begin
            got = (tb0 + i < tx_q.size()) ? int'(tx_q[tb0 + i]) : 32'hDEAD;
            chk($sformatf("v%0d_byte%0d", idx, i), got, 32'(v.exp[63 - 8*i -: 8]));
        end
        chk($sformatf("v%0d_nreads", idx), rd_q.size() - rb0, 32'(v.cnt));
        for (int i = 0; i < int'(v.cnt) && rb0 + i < rd_q.size(); i++) begin
            ea = v.raddr0 + AW'(2 * i);
            chk($sformatf("v%0d_raddr%0d", idx, i), 32'(rd_q[rb0 + i]), 32'(ea));
        end
        chk($sformatf("v%0d_tx_while_busy", idx), viol - v0, 0);
        chk($sformatf("v%0d_tx_spacing", idx), gap_viol - g0, 0);
    endtask

    initial begin
        int  tb0, rb0;
        bit  seen;
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
        mem[12'h180] = 16'h1234;
        mem[12'h181] = 16'hABCD;
        mem[12'h182] = 16'h5566;
        mem[12'h7FF] = 16'hC3A5;
        mem[12'h000] = 16'h0F1E;
        mem[12'h200] = 16'hFFFF;
        mem[12'h201] = 16'h0102;

        vecs[0] = '{addr:12'h300, cnt:11'd2, raddr0:12'h300, lag:8'd0, hold:8'd0,  poke:1'b0, nexp:4'd6, exp:64'h1234_ABCD_FFFF_0000};
        vecs[1] = '{addr:12'h300, cnt:11'd0, raddr0:12'h300, lag:8'd0, hold:8'd2,  poke:1'b0, nexp:4'd2, exp:64'hFFFF_0000_0000_0000};
        vecs[2] = '{addr:12'hFFF, cnt:11'd2, raddr0:12'hFFE, lag:8'd0, hold:8'd1,  poke:1'b0, nexp:4'd6, exp:64'hC3A5_0F1E_FFFF_0000};
        vecs[3] = '{addr:12'h301, cnt:11'd2, raddr0:12'h300, lag:8'd1, hold:8'd10, poke:1'b1, nexp:4'd6, exp:64'h1234_ABCD_FFFF_0000};
        vecs[4] = '{addr:12'h400, cnt:11'd2, raddr0:12'h400, lag:8'd0, hold:8'd3,  poke:1'b0, nexp:4'd6, exp:64'hFFFF_0102_FFFF_0000};
        vecs[5] = '{addr:12'h300, cnt:11'd1, raddr0:12'h300, lag:8'd1, hold:8'd1,  poke:1'b0, nexp:4'd4, exp:64'h1234_FFFF_0000_0000};

        start = 1'b0; abort = 1'b0; start0 = 1'b0;
        start_addr = '0; count = '0; lag = 0; hold = 0;

        repeat (3) @(negedge sys_clk);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_done",     32'(done),         32'd0);
        chk("rst_tx_en",    32'(if1.tx_en),    32'd0);
        chk("rst_tx_data",  32'(if1.tx_data),  32'd0);
        chk("rst_mem_rd",   32'(if1.mem_rd),   32'd0);
        chk("rst_mem_addr", 32'(if1.mem_addr), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("post_rst_no_tx", tx_q.size(), 0);
        chk("post_rst_idle",  32'(busy), 32'd0);

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // count 0 without terminator: done next cycle, nothing sent
        @(negedge sys_clk);
        start0 = 1'b1;
        @(negedge sys_clk);
        start0 = 1'b0;
        chk("nt_done",  32'(done0), 32'd1);
        chk("nt_busy",  32'(busy0), 32'd0);
        @(negedge sys_clk);
        chk("nt_done_end", 32'(done0), 32'd0);
        repeat (4) @(negedge sys_clk);
        chk("nt_no_bytes", en0_cnt, 0);
        chk("nt_no_reads", rd0_cnt, 0);

        // start and abort together in IDLE: abort wins
        tb0 = tx_q.size(); rb0 = rd_q.size();
        @(negedge sys_clk);
        start = 1'b1; abort = 1'b1; start_addr = 12'h300; count = 11'd2;
        @(negedge sys_clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge sys_clk);
        chk("sa_no_bytes", tx_q.size() - tb0, 0);
        chk("sa_no_reads", rd_q.size() - rb0, 0);

        // abort while waiting in LO of the first of three words
        lag = 0; hold = 10;
        tb0 = tx_q.size();
        @(negedge sys_clk);
        start = 1'b1; start_addr = 12'h300; count = 11'd3;
        @(negedge sys_clk);
        start = 1'b0;
        for (int c = 0; c < 100 && tx_q.size() == tb0; c++) @(negedge sys_clk);
        chk("ab_first_byte_seen", 32'(tx_q.size() > tb0), 32'd1);
        repeat (3) @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        chk("ab_busy",   32'(busy),       32'd0);
        chk("ab_tx_en",  32'(if1.tx_en),  32'd0);
        chk("ab_mem_rd", 32'(if1.mem_rd), 32'd0);
        chk("ab_done",   32'(done),       32'd0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge sys_clk);
            if (done) seen = 1'b1;
        end
        chk("ab_no_done", 32'(seen), 32'd0);
        chk("ab_nbytes", tx_q.size() - tb0, 1);
        chk("ab_byte0", (tx_q.size() > tb0) ? int'(tx_q[tb0]) : 32'hDEAD, 32'h12);
        run_vec(vecs[0], 10);

        // asynchronous reset in the middle of a transfer
        lag = 0; hold = 0;
        tb0 = tx_q.size();
        @(negedge sys_clk);
        start = 1'b1; start_addr = 12'h300; count = 11'd2;
        @(negedge sys_clk);
        start = 1'b0;
        for (int c = 0; c < 100 && tx_q.size() == tb0; c++) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy",     32'(busy),         32'd0);
        chk("mr_tx_en",    32'(if1.tx_en),    32'd0);
        chk("mr_tx_data",  32'(if1.tx_data),  32'd0);
        chk("mr_mem_rd",   32'(if1.mem_rd),   32'd0);
        chk("mr_mem_addr", 32'(if1.mem_addr), 32'd0);
        chk("mr_done",     32'(done),         32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        tb0 = tx_q.size();
        repeat (6) @(negedge sys_clk);
        chk("mr_no_tx_after", tx_q.size() - tb0, 0);
        chk("mr_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
